// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared definitions for the multicycle RISC-V control path:
//   - state_t    : FSM state encoding (also exported on state_dbg)
//   - OP_*       : supported major opcodes (instruction bits [6:0])
//   - FMT_*      : immediate-format / ALU-op encoding (ImmSel and AluOp share it)
//   - M2R_*      : MemtoReg select encoding
//   - PCS_*      : PCSrc select encoding
//   - dec_t      : per-opcode control fields produced by ctrl_decode
//   - wb_pc_src(): next-PC select used in the write-back state
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_J = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_R = 3'd5;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  localparam logic [1:0] PCS_PC4    = 2'd0;
  localparam logic [1:0] PCS_TARGET = 2'd1;
  localparam logic [1:0] PCS_JALR   = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [2:0] fmt;
    logic       alu_src;
    logic [1:0] mem_to_reg;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
  } dec_t;

  // jal jumps to the adder target, jalr to the ALU result, everything else
  // that reaches write-back simply advances to PC+4.
  function automatic logic [1:0] wb_pc_src(input logic is_jal, input logic is_jalr);
    if (is_jal)       return PCS_TARGET;
    else if (is_jalr) return PCS_JALR;
    else              return PCS_PC4;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Pure combinational opcode decoder for the multicycle controller.
// Ports:
//   opcode     (in,  7) latched instruction bits [6:0]
//   valid      (out, 1) opcode is one of the supported major opcodes
//   fmt        (out, 3) immediate format, also used as the ALU operation class
//   alu_src    (out, 1) ALU operand B comes from the immediate
//   mem_to_reg (out, 2) write-back data select
//   is_load / is_store / is_branch / is_jal / is_jalr (out, 1) class flags
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       valid,
  output logic [2:0] fmt,
  output logic       alu_src,
  output logic [1:0] mem_to_reg,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr
);

  dec_t dec;

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    case (opcode)
      OP_R: begin
        dec.fmt = FMT_R;
      end
      OP_LOAD: begin
        dec.fmt        = FMT_I;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = M2R_MEM;
        dec.is_load    = 1'b1;
      end
      OP_IMM: begin
        dec.fmt     = FMT_I;
        dec.alu_src = 1'b1;
      end
      OP_JALR: begin
        dec.fmt        = FMT_I;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = M2R_PC4;
        dec.is_jalr    = 1'b1;
      end
      OP_STORE: begin
        dec.fmt      = FMT_S;
        dec.alu_src  = 1'b1;
        dec.is_store = 1'b1;
      end
      OP_BRANCH: begin
        dec.fmt       = FMT_B;
        dec.is_branch = 1'b1;
      end
      OP_LUI: begin
        dec.fmt     = FMT_U;
        dec.alu_src = 1'b1;
      end
      OP_JAL: begin
        dec.fmt        = FMT_J;
        dec.mem_to_reg = M2R_PC4;
        dec.is_jal     = 1'b1;
      end
      default: begin
        dec.valid = 1'b0;
      end
    endcase
  end

  assign valid      = dec.valid;
  assign fmt        = dec.fmt;
  assign alu_src    = dec.alu_src;
  assign mem_to_reg = dec.mem_to_reg;
  assign is_load    = dec.is_load;
  assign is_store   = dec.is_store;
  assign is_branch  = dec.is_branch;
  assign is_jal     = dec.is_jal;
  assign is_jalr    = dec.is_jalr;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for a multicycle RISC-V datapath: IDLE -> FETCH -> DECODE ->
// EXEC -> (MEM) -> (WB) -> FETCH, with a sticky TRAP on unsupported opcodes.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode[6:0]           instruction bits, captured when ir_write=1
//   branch_taken          comparator result, used in EXEC of a branch
//   imem_ready            instruction memory done (only meaningful with imem_req)
//   dmem_ready            data memory done (only meaningful with MemRead/MemWrite)
//   imem_req, ir_write, pc_write, RegWrite, MemRead, MemWrite, AluSrc
//   MemtoReg[1:0], PCSrc[1:0], ImmSel[2:0], AluOp[2:0]
//   retire                one pulse per completed instruction
//   trap                  held high while stopped on an unsupported opcode
//   state_dbg[2:0]        current FSM state (riscv_ctrl_pkg::state_t)
//   instret[31:0]         retired-instruction counter, wraps to 0
//
// Memory handshake: a request (imem_req, MemRead or MemWrite) is held high
// from the first cycle of its state until the cycle in which the matching
// ready is sampled high; that cycle completes the transfer. A ready seen while
// its request is low has no effect. Ready may arrive in the request's first
// cycle (zero-wait).
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        AluSrc,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ImmSel,
  output logic [2:0]  AluOp,
  output logic        retire,
  output logic        trap,
  output logic [2:0]  state_dbg,
  output logic [31:0] instret
);

  state_t      state_q;
  logic [6:0]  opcode_q;
  logic [31:0] instret_q;

  logic       dec_valid;
  logic [2:0] dec_fmt;
  logic       dec_alu_src;
  logic [1:0] dec_mem_to_reg;
  logic       dec_is_load;
  logic       dec_is_store;
  logic       dec_is_branch;
  logic       dec_is_jal;
  logic       dec_is_jalr;

  // Decode always works from the latched opcode so the fields stay stable
  // for the whole instruction even if the opcode input moves.
  ctrl_decode u_decode (
    .opcode     (opcode_q),
    .valid      (dec_valid),
    .fmt        (dec_fmt),
    .alu_src    (dec_alu_src),
    .mem_to_reg (dec_mem_to_reg),
    .is_load    (dec_is_load),
    .is_store   (dec_is_store),
    .is_branch  (dec_is_branch),
    .is_jal     (dec_is_jal),
    .is_jalr    (dec_is_jalr)
  );

  logic in_instr;

  // Outputs are decoded from the state register and latched opcode; the
  // memory ready inputs only qualify the completing strobes of their state.
  always_comb begin
    imem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    AluSrc   = 1'b0;
    MemtoReg = M2R_ALU;
    PCSrc    = PCS_PC4;
    ImmSel   = FMT_I;
    AluOp    = FMT_I;
    retire   = 1'b0;
    trap     = 1'b0;

    // Datapath selects are live from DECODE until the instruction finishes.
    in_instr = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
               (state_q == ST_MEM)    || (state_q == ST_WB);
    if (in_instr && dec_valid) begin
      ImmSel   = dec_fmt;
      AluOp    = dec_fmt;
      AluSrc   = dec_alu_src;
      MemtoReg = dec_mem_to_reg;
    end

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      ST_EXEC: begin
        // Branches complete here; the comparator picks target vs PC+4.
        if (dec_is_branch) begin
          pc_write = 1'b1;
          retire   = 1'b1;
          PCSrc    = branch_taken ? PCS_TARGET : PCS_PC4;
        end
      end
      ST_MEM: begin
        MemRead  = dec_is_load;
        MemWrite = dec_is_store;
        // Stores have nothing to write back, so they retire on completion.
        if (dec_is_store && dmem_ready) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        pc_write = 1'b1;
        retire   = 1'b1;
        PCSrc    = wb_pc_src(dec_is_jal, dec_is_jalr);
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= 7'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            opcode_q <= opcode;
            state_q  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_q <= dec_valid ? ST_EXEC : ST_TRAP;
        end
        ST_EXEC: begin
          if (dec_is_branch)                    state_q <= ST_FETCH;
          else if (dec_is_load || dec_is_store) state_q <= ST_MEM;
          else                                  state_q <= ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready) state_q <= dec_is_load ? ST_WB : ST_FETCH;
        end
        ST_WB: begin
          state_q <= ST_FETCH;
        end
        ST_TRAP: begin
          state_q <= ST_TRAP;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // retire is already gated to exactly one cycle per instruction and is
  // never high in TRAP, so the counter needs no further qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 32'd0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret   = instret_q;
  assign state_dbg = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 7, instruction bits [6:0], sampled only when ir_write=1.
REQ-004 SHALL have port branch_taken, input, 1, OR of Equal/NEqual/Less_Than/Greater_Equal from the comparator, sampled in EXEC.
REQ-005 SHALL have port imem_ready, input, 1, instruction memory done; imem_req SHALL be held until it is seen.
REQ-006 SHALL have port dmem_ready, input, 1, data memory done; MemRead/MemWrite SHALL be held until it is seen.
REQ-007 SHALL have outputs imem_req, ir_write, pc_write, RegWrite, MemRead, MemWrite, AluSrc, each 1 bit.
REQ-008 SHALL have outputs MemtoReg[1:0], PCSrc[1:0], ImmSel[2:0], AluOp[2:0], using the single-cycle encodings.
REQ-009 SHALL have outputs retire (1), trap (1), state_dbg (3) and instret (32).

Function
REQ-010 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
REQ-011 IDLE SHALL go to FETCH after one cycle, driving all strobes 0.
REQ-012 FETCH SHALL assert imem_req; on imem_ready it SHALL pulse ir_write, latch opcode and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-013 DECODE SHALL last one cycle; an unsupported opcode SHALL go to TRAP, any other to EXEC.
REQ-014 Supported opcodes: 0110011 R, 0000011 load, 0010011 I, 1100111 jalr, 0100011 store, 1100011 branch, 0110111 lui, 1101111 jal.
REQ-015 ImmSel and AluOp SHALL be I=0, S=1, B=2, J=3, U=4, R=5, driven from DECODE through the last state of the instruction.
REQ-016 AluSrc SHALL be 1 for load/I/jalr/store/lui and 0 otherwise.
REQ-017 MemtoReg SHALL be 1 for load, 2 for jal/jalr and 0 otherwise.
REQ-018 EXEC transitions: R/I/lui/jal/jalr SHALL go to WB; load/store SHALL go to MEM; branch SHALL go to FETCH.
REQ-019 In EXEC, a branch SHALL pulse pc_write and retire, with PCSrc=1 if branch_taken, else 0.
REQ-020 MEM SHALL assert MemRead (load) or MemWrite (store) until dmem_ready; load SHALL then go to WB.
REQ-021 On dmem_ready, store SHALL pulse pc_write and retire (PCSrc=0) and go to FETCH.
REQ-022 WB SHALL last one cycle, pulsing RegWrite, pc_write and retire, then go to FETCH.
REQ-023 PCSrc in WB SHALL be 1 for jal, 2 for jalr and 0 otherwise.
REQ-024 pc_write and retire SHALL each pulse exactly once per completed instruction; RegWrite SHALL never be asserted outside WB.
REQ-025 All outputs SHALL be combinational from the state register and latched opcode, except instret.
REQ-026 instret SHALL increment on each retire and wrap 0xFFFFFFFF to 0.
REQ-027 TRAP SHALL hold trap=1, with all strobes 0 and no instret change, until reset.
REQ-028 Minimum latency with zero-wait memory (ready in the request cycle): branch 3 cycles; R/I/lui/jal/jalr/store 4; load 5.
REQ-029 A ready input arriving while its request is not asserted SHALL be ignored.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously set state=IDLE, clear the latched opcode to 0 and clear instret to 0.
REQ-031 During reset all strobes, trap and retire SHALL be 0; MemtoReg/PCSrc/ImmSel/AluOp SHALL be 0; state_dbg SHALL be 0.
REQ-032 Reset asserted mid-MEM or mid-FETCH SHALL drop the request in the same cycle, with no retire.

Structure
REQ-033 State encodings, opcode constants and the ImmSel/AluOp/MemtoReg/PCSrc encodings SHALL live in a shared package, riscv_ctrl_pkg.
REQ-034 The opcode-to-field decode SHALL be a sub-module, ctrl_decode, instantiated from the latched opcode.

Verification
REQ-035 R-type (0110011), zero-wait: states SHALL follow 1,2,3,5,1, with RegWrite=1 only in WB, MemtoReg=0 and instret 0 to 1.
REQ-036 Load with dmem_ready delayed 3 cycles: MemRead SHALL be held 4 cycles, then WB with MemtoReg=1; total latency 8 cycles.
REQ-037 Branch with branch_taken=1 then 0: pc_write SHALL pulse in EXEC with PCSrc=1 then 0, RegWrite never set, 3 cycles each.
REQ-038 jalr: WB SHALL show PCSrc=2 and MemtoReg=2; opcode 1111111 SHALL give trap=1 permanently, cleared only by rst_n.
REQ-039 instret preset near 0xFFFFFFFF (force), then 2 retires: SHALL read 0x00000001.
REQ-040 rst_n low during MEM of a store: MemWrite SHALL drop to 0 immediately, state_dbg=0, no retire.
